// File: rtl/restoring_divider_if.sv
// rtl/restoring_divider_if.sv - operand/result bundle for restoring_divider
//
// Purpose : groups the request (start + operands) and the result
//           (busy/done/quotient/remainder/dz) signals of the divider.
// Signals :
//   start     - request to begin a division (master -> slave)
//   dividend  - N-bit unsigned dividend       (master -> slave)
//   divisor   - N-bit unsigned divisor        (master -> slave)
//   busy      - high while the divider is running (slave -> master)
//   done      - one-cycle completion pulse        (slave -> master)
//   quotient  - N-bit unsigned quotient           (slave -> master)
//   remainder - N-bit unsigned remainder          (slave -> master)
//   dz        - divide-by-zero flag               (slave -> master)
// Modports: master (requester side), slave (divider side).

interface restoring_divider_if #(
   parameter int N = 4
);
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         dz;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, dz
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, dz
   );
endinterface

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - N-bit unsigned restoring divider, one step per clock
//
// Purpose : divides an N-bit unsigned dividend by an N-bit unsigned divisor
//           using the restoring algorithm, one quotient bit per RUN cycle.
//           FSM: IDLE -> RUN (N steps) -> DONE (one cycle) -> IDLE.
// Ports   :
//   clk - single clock, all state changes on its rising edge
//   rst - synchronous active-high reset, has priority over start
//   bus - restoring_divider_if.slave: start/dividend/divisor in,
//         busy/done/quotient/remainder/dz out
// Config  : DIVIDER_DIV_ZERO_CHECK_EN
//   undefined - dz tied to 0; a zero divisor runs the normal N steps and
//               naturally yields quotient = all ones, remainder = dividend.
//   defined   - a zero divisor at start acceptance skips RUN and goes
//               straight to DONE with dz = 1, quotient = all ones,
//               remainder = dividend.

module restoring_divider #(
   parameter int N = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   restoring_divider_if.slave   bus
);

   localparam int CW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next_state;

   // Partial remainder between steps. The working (shifted) value is N+1
   // bits wide; the kept result of every step is strictly less than the
   // divisor, so its top bit is always zero and N bits hold it losslessly.
   logic [N-1:0]    r_pr;
   logic [N-1:0]    r_dvd;        // dividend shift register, MSB consumed first
   logic [N-1:0]    r_dvs;        // captured divisor
   logic [N-1:0]    r_q;          // quotient bits accumulated so far
   logic [CW-1:0]   r_cnt;        // step counter, 0 .. N-1
   logic [N-1:0]    r_quotient;
   logic [N-1:0]    r_remainder;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
   logic            r_dz;
`endif

   logic            w_accept;
   logic            w_last;
   logic            w_zero_div;
   logic [N:0]      w_shift;
   logic [N-1:0]    w_diff;
   logic            w_borrow;
   logic            w_qbit;
   logic [N-1:0]    w_step_pr;

`ifdef DIVIDER_DIV_ZERO_CHECK_EN
   assign w_zero_div = (bus.divisor == '0);
`else
   assign w_zero_div = 1'b0;
`endif

   // One restoring step: shift the next dividend bit in, then subtract the
   // zero-extended divisor with an explicit ripple borrow (borrow-in 0).
   assign w_shift = {r_pr, r_dvd[N-1]};

   always_comb begin
      w_diff   = '0;
      w_borrow = 1'b0;
      for (int i = 0; i < N; i++) begin
         w_diff[i] = w_shift[i] ^ r_dvs[i] ^ w_borrow;
         w_borrow  = (~w_shift[i] & r_dvs[i]) |
                     (~(w_shift[i] ^ r_dvs[i]) & w_borrow);
      end
      // Bit N of the zero-extended divisor is 0; only the borrow survives.
      w_borrow = ~w_shift[N] & w_borrow;
   end

   // No borrow: the divisor fits, keep the difference. Otherwise restore.
   assign w_qbit    = ~w_borrow;
   assign w_step_pr = w_borrow ? w_shift[N-1:0] : w_diff;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_last       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_accept     = 1'b1;
               w_next_state = w_zero_div ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            if (r_cnt == CW'(N - 1)) begin
               w_last       = 1'b1;
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pr        <= '0;
         r_dvd       <= '0;
         r_dvs       <= '0;
         r_q         <= '0;
         r_cnt       <= '0;
         r_quotient  <= '0;
         r_remainder <= '0;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
         r_dz        <= 1'b0;
`endif
      end else if (w_accept) begin
         r_pr  <= '0;
         r_dvd <= bus.dividend;
         r_dvs <= bus.divisor;
         r_q   <= '0;
         r_cnt <= '0;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
         r_dz  <= w_zero_div;
         if (w_zero_div) begin
            r_quotient  <= '1;
            r_remainder <= bus.dividend;
         end
`endif
      end else if (r_state == S_RUN) begin
         r_pr  <= w_step_pr;
         r_dvd <= {r_dvd[N-2:0], 1'b0};
         r_q   <= {r_q[N-2:0], w_qbit};
         r_cnt <= r_cnt + 1'b1;
         // Results only move on the RUN->DONE edge so they stay stable
         // for the whole of the next operation's RUN phase.
         if (w_last) begin
            r_quotient  <= {r_q[N-2:0], w_qbit};
            r_remainder <= w_step_pr;
         end
      end
   end

   // ------------------------------------------------------------ outputs
   assign bus.busy      = (r_state == S_RUN);
   assign bus.done      = (r_state == S_DONE);
   assign bus.quotient  = r_quotient;
   assign bus.remainder = r_remainder;
`ifdef DIVIDER_DIV_ZERO_CHECK_EN
   assign bus.dz        = r_dz;
`else
   assign bus.dz        = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - directed self-checking bench for restoring_divider

module tb_restoring_divider;

   localparam int N = 4;

`ifdef DIVIDER_DIV_ZERO_CHECK_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   restoring_divider_if #(.N(N)) dif ();

   restoring_divider #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Issues one division at the current negedge and follows it cycle by
   // cycle: busy for lat cycles, then a single done cycle with results,
   // then one idle cycle. Returns at the negedge where a new start would
   // be accepted on the following edge. With keep=1, start stays high and
   // the operands are scrambled after acceptance.
   task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] eq, input logic [N-1:0] er,
                         input logic edz, input int lat, input bit keep,
                         input string name, output time t_done);
      t_done       = 0;
      dif.start    = 1'b1;
      dif.dividend = a;
      dif.divisor  = b;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i <= lat + 1; i++) begin
         if (keep) begin
            dif.dividend = ~a;
            dif.divisor  = ~b;
         end else begin
            dif.start = 1'b0;
         end
         if (i < lat) begin
            n_tests++;
            if (dif.busy !== 1'b1 || dif.done !== 1'b0) begin
               n_fail++;
               $display("FAIL %s run cycle %0d: busy=%b done=%b expected busy=1 done=0",
                        name, i, dif.busy, dif.done);
            end
         end else if (i == lat) begin
            t_done = $time;
            n_tests++;
            if (dif.done !== 1'b1 || dif.busy !== 1'b0) begin
               n_fail++;
               $display("FAIL %s done cycle: busy=%b done=%b expected busy=0 done=1",
                        name, dif.busy, dif.done);
            end
            n_tests++;
            if (dif.quotient !== eq || dif.remainder !== er || dif.dz !== edz) begin
               n_fail++;
               $display("FAIL %s result: q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b",
                        name, dif.quotient, dif.remainder, dif.dz, eq, er, edz);
            end
         end else begin
            n_tests++;
            if (dif.done !== 1'b0 || dif.busy !== 1'b0) begin
               n_fail++;
               $display("FAIL %s after done: busy=%b done=%b expected busy=0 done=0",
                        name, dif.busy, dif.done);
            end
         end
         if (i <= lat) @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      dif.start    = 1'b1;
      dif.dividend = 4'd13;
      dif.divisor  = 4'd3;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.quotient !== 4'd0 ||
          dif.remainder !== 4'd0 || dif.dz !== 1'b0) begin
         n_fail++;
         $display("FAIL reset outputs: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
                  dif.busy, dif.done, dif.quotient, dif.remainder, dif.dz);
      end
      rst       = 1'b0;
      dif.start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (dif.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset idle: busy=%b expected 0", dif.busy);
      end
   endtask

   task automatic test_basic();
      time t;
      do_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, N, 1'b0, "basic 13/3", t);
   endtask

   task automatic test_sweep();
      time t;
      do_div(4'd15, 4'd1,  4'd15, 4'd0, 1'b0, N, 1'b0, "sweep 15/1", t);
      do_div(4'd0,  4'd7,  4'd0,  4'd0, 1'b0, N, 1'b0, "sweep 0/7", t);
      do_div(4'd5,  4'd9,  4'd0,  4'd5, 1'b0, N, 1'b0, "sweep 5/9", t);
      do_div(4'd15, 4'd15, 4'd1,  4'd0, 1'b0, N, 1'b0, "sweep 15/15", t);
   endtask

   task automatic test_back_to_back();
      time t;
      time t_prev;
      t_prev = 0;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) do_div(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, N, 1'b1, "b2b 13/3", t);
         else            do_div(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, N, 1'b1, "b2b 14/4", t);
         if (k > 0) begin
            n_tests++;
            if (t - t_prev != 60) begin
               n_fail++;
               $display("FAIL b2b interval: got %0t expected 60", t - t_prev);
            end
         end
         t_prev = t;
      end
      dif.start = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      time t;
      dif.start    = 1'b1;
      dif.dividend = 4'd13;
      dif.divisor  = 4'd3;
      @(posedge clk);           // accept
      @(negedge clk);
      dif.start = 1'b0;
      @(posedge clk);           // first RUN edge
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);           // second RUN edge, reset wins
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.quotient !== 4'd0 ||
          dif.remainder !== 4'd0 || dif.dz !== 1'b0) begin
         n_fail++;
         $display("FAIL midrun reset: busy=%b done=%b q=%0d r=%0d dz=%b expected all 0",
                  dif.busy, dif.done, dif.quotient, dif.remainder, dif.dz);
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_tests++;
         if (dif.done !== 1'b0 || dif.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun no done cycle %0d: busy=%b done=%b expected 0 0",
                     i, dif.busy, dif.done);
         end
      end
      do_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, N, 1'b0, "after reset 7/2", t);
   endtask

   task automatic test_div_zero();
      time t;
      do_div(4'd9, 4'd0, 4'd15, 4'd9, DZ_EN, DZ_EN ? 0 : N, 1'b0, "div zero 9/0", t);
   endtask

   task automatic test_exhaustive();
      time t;
      int  eq, er, lat;
      bit  edz;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) begin
               eq  = 15;
               er  = a;
               edz = DZ_EN;
               lat = DZ_EN ? 0 : N;
            end else begin
               eq  = a / b;
               er  = a % b;
               edz = 1'b0;
               lat = N;
            end
            do_div(4'(a), 4'(b), 4'(eq), 4'(er), edz, lat, 1'b0,
                   $sformatf("exhaustive %0d/%0d", a, b), t);
         end
      end
   endtask

   initial begin
      rst          = 1'b1;
      dif.start    = 1'b0;
      dif.dividend = '0;
      dif.divisor  = '0;
      test_reset();
      test_basic();
      test_sweep();
      test_back_to_back();
      test_reset_mid_run();
      test_div_zero();
      test_exhaustive();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/restoring_divider.md
RESTORING_DIVIDER -- requirements
Module: restoring_divider

Interface
REQ-001 SHALL have parameter N, default 4, meaning operand/result width in bits (N >= 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, N, unsigned dividend; captured on the edge that accepts start.
REQ-006 SHALL have port divisor, input, N, unsigned divisor; captured on the same edge.
REQ-007 SHALL have port busy, output, 1, high while the state is RUN.
REQ-008 SHALL have port done, output, 1, single-cycle completion pulse.
REQ-009 SHALL have port quotient, output, N, unsigned quotient; held stable until the next accepted start.
REQ-010 SHALL have port remainder, output, N, unsigned remainder; held stable until the next accepted start.
REQ-011 SHALL have port dz, output, 1, divide-by-zero flag; valid while done is high and held until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE, with transitions IDLE->RUN on start, RUN->DONE after N steps, and DONE->IDLE unconditionally.
REQ-013 SHALL ignore start in RUN and DONE, with no queuing and no operand recapture.
REQ-014 SHALL perform, on each RUN edge, one restoring step: shift the (N+1)-bit partial remainder left, shift in the next dividend bit (MSB first), then subtract zero-extended divisor with ripple borrow and borrow-in 0.
REQ-015 SHALL set the quotient bit to 1 and keep the difference when the step's borrow-out is 0, and SHALL otherwise set the quotient bit to 0 and restore the shifted value.
REQ-016 SHALL update quotient and remainder (low N bits of the partial remainder) on the RUN->DONE edge.
REQ-017 SHALL give latency such that, if start is accepted at edge k, busy is high after edges k..k+N-1 and done is high only in the cycle following edge k+N.
REQ-018 SHALL permit back-to-back operation: start is accepted on the DONE->IDLE+1 edge, so the minimum issue interval is N+2 cycles.
REQ-019 SHALL never lose bits through intermediate overflow: the partial remainder is N+1 bits wide, and quotient*divisor+remainder SHALL equal dividend with remainder < divisor whenever divisor != 0.
REQ-020 SHALL handle a zero divisor according to REQ-027 and REQ-028.

Reset
REQ-021 SHALL, on rst high at a clock edge, set state to IDLE, busy=0, done=0, quotient=0, remainder=0, dz=0, and clear the step counter and partial remainder.
REQ-022 SHALL abort any operation in progress when rst is asserted mid-RUN or mid-DONE, producing no done pulse for the aborted operation.
REQ-023 SHALL give rst priority over start on the same edge.

Configuration
REQ-024 SHALL use macro DIVIDER_DIV_ZERO_CHECK_EN.
REQ-025 SHALL keep the port list identical whether or not the macro is defined.
REQ-026 SHALL, with the macro undefined, tie dz to 0.
REQ-027 SHALL, with the macro defined and divisor==0 at start acceptance, go IDLE->DONE directly with done high in the cycle after edge k, dz=1, quotient=all ones and remainder=dividend.
REQ-028 SHALL, with the macro undefined and divisor==0, run the normal N steps and yield quotient=all ones and remainder=dividend (natural restoring result) at the REQ-017 latency.

Verification (N=4)
REQ-029 SHALL cover: dividend=13, divisor=3, start at edge k -> busy for 4 cycles, done only after edge k+4, quotient=4, remainder=1, dz=0.
REQ-030 SHALL cover: operand sweeps 15/1, 0/7, 5/9, 15/15 -> quotient/remainder of 15/0, 0/0, 0/5 and 1/0 respectively.
REQ-031 SHALL cover: start held high continuously with alternating operands -> one result per 6 cycles, and operand changes during RUN do not affect the result.
REQ-032 SHALL cover: rst pulsed at the second RUN edge -> all outputs 0, no done pulse, and a new start afterwards completes correctly.
REQ-033 SHALL cover: dividend=9, divisor=0 -> with the macro, done after edge k, dz=1, quotient=15, remainder=9; without the macro, done after edge k+4, dz=0, quotient=15, remainder=9.
REQ-034 SHALL cover: exhaustive 256 operand pairs against a reference model checking REQ-019.
